// File: rtl/otter_div_if.sv
// Divider request/write-back bundle between core control, register-file read ports and write port.
interface otter_div_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [AW-1:0]   rd;
    logic            abort;
    logic            busy;
    logic            done;
    logic            w_en;
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;

    modport master (
        output start, op, rs1, rs2, rd, abort,
        input  busy, done, w_en, w_addr, w_data
    );

    modport slave (
        input  start, op, rs1, rs2, rd, abort,
        output busy, done, w_en, w_addr, w_data
    );
endinterface

// File: rtl/otter_div.sv
// Iterative RV32M restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define OTTER_DIV_FASTPATH_EN to retire divide-by-zero and signed overflow directly from IDLE.
module otter_div (
    input  logic       clk,
    input  logic       rst,
    otter_div_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 6;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

`ifdef OTTER_DIV_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q, rs1_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   rd_q;
    logic            is_rem_q, q_neg_q, r_neg_q, div0_q, ovf_q;
    logic [AW-1:0]   w_addr_q;
    logic [XLEN-1:0] w_data_q;

    logic            accept, signed_op, a_neg, b_neg, div0, ovf, special;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            ge;
    logic [XLEN-1:0] rem_step, quo_step, final_res;

    // Override result for the RISC-V mandated corner cases (div0 wins over overflow)
    function automatic logic [XLEN-1:0] special_result(input logic is_rem,
                                                       input logic [XLEN-1:0] dividend,
                                                       input logic is_div0);
        if (is_div0) return is_rem ? dividend : '1;
        return is_rem ? '0 : INT_MIN;
    endfunction

    // Operand decode in IDLE
    always_comb begin
        accept    = bus.start && !bus.abort;
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.rs1[XLEN-1];
        b_neg     = signed_op & bus.rs2[XLEN-1];
        a_mag     = a_neg ? XLEN'(-bus.rs1) : bus.rs1;
        b_mag     = b_neg ? XLEN'(-bus.rs2) : bus.rs2;
        div0      = (bus.rs2 == '0);
        ovf       = signed_op && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);
        special   = div0 | ovf;
    end

    // One restoring step; the extra borrow bit keeps divisors >= 2^31 exact
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = {1'b0, shifted} - {2'b00, dvsr_q};
        ge        = ~diff[XLEN+1];
        rem_step  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_step  = {quo_q[XLEN-2:0], ge};
        if (div0_q || ovf_q) begin
            final_res = special_result(is_rem_q, rs1_q, div0_q);
        end else if (is_rem_q) begin
            final_res = r_neg_q ? XLEN'(-rem_step) : rem_step;
        end else begin
            final_res = q_neg_q ? XLEN'(-quo_step) : quo_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (FASTPATH && special) ? DONE : CALC;
            CALC: begin
                if (bus.abort)                state_nxt = IDLE;
                else if (cnt_q == LAST_STEP)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and write-back registers; w_addr/w_data only change on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            rs1_q    <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rem_q    <= '0;
                    quo_q    <= a_mag;
                    dvsr_q   <= b_mag;
                    rs1_q    <= bus.rs1;
                    cnt_q    <= '0;
                    rd_q     <= bus.rd;
                    is_rem_q <= bus.op[1];
                    q_neg_q  <= a_neg ^ b_neg;
                    r_neg_q  <= a_neg;
                    div0_q   <= div0;
                    ovf_q    <= ovf;
                    if (FASTPATH && special) begin
                        w_addr_q <= bus.rd;
                        w_data_q <= special_result(bus.op[1], bus.rs1, div0);
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP && !bus.abort) begin
                        w_addr_q <= rd_q;
                        w_data_q <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.w_en   = (state == DONE) && (w_addr_q != '0);
    assign bus.w_addr = w_addr_q;
    assign bus.w_data = w_data_q;
endmodule
